// File: rtl/sfu_pkg.sv
// Shared types and arithmetic helpers for the SFU accumulation buffer.
package sfu_pkg;
  localparam int PSUM_BW = 16;

  typedef logic signed [PSUM_BW-1:0] psum_t;

  localparam psum_t PSUM_MAX = psum_t'({1'b0, {(PSUM_BW-1){1'b1}}});
  localparam psum_t PSUM_MIN = psum_t'({1'b1, {(PSUM_BW-1){1'b0}}});

  function automatic psum_t relu(input psum_t a);
    return a[PSUM_BW-1] ? psum_t'(0) : a;
  endfunction

  // One extra bit catches overflow: top two bits disagree when out of range.
  function automatic psum_t sat_add(input psum_t a, input psum_t b, output logic sat);
    logic signed [PSUM_BW:0] s;
    s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
    sat = s[PSUM_BW] ^ s[PSUM_BW-1];
    if (!sat) return s[PSUM_BW-1:0];
    return s[PSUM_BW] ? PSUM_MIN : PSUM_MAX;
  endfunction
endpackage

// File: rtl/sfu_lane.sv
// One column of the accumulation datapath: load/add mux, optional clamp, ReLU.
// SFU_ACC_SAT_EN selects clamping accumulation; otherwise it wraps.
module sfu_lane
  import sfu_pkg::*;
(
  input  psum_t psum_in,
  input  psum_t buf_q,
  input  logic  load,
  input  logic  relu_en,
  output psum_t sum,
  output psum_t res,
  output logic  sat
);
  always_comb begin
    sum = psum_in;
    sat = 1'b0;
    if (!load) begin
`ifdef SFU_ACC_SAT_EN
      sum = sat_add(buf_q, psum_in, sat);
`else
      sum = buf_q + psum_in;
`endif
    end
    res = relu_en ? relu(sum) : sum;
  end
endmodule

// File: rtl/sfu_accum_buf.sv
// Multi-entry per-column psum accumulation buffer with bypass and a one-deep
// valid/ready output register. SFU_ACC_SAT_EN enables saturating accumulate.
module sfu_accum_buf
  import sfu_pkg::*;
#(
  parameter int col   = 8,
  parameter int depth = 16,
  localparam int psum_bw = PSUM_BW,
  localparam int aw      = $clog2(depth)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [aw-1:0]          in_addr,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic                   bypass_i,
  input  logic                   relu_en,
  input  logic [col*psum_bw-1:0] psum_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [aw-1:0]          out_addr,
  output logic [col*psum_bw-1:0] psum_out,
  output logic                   err_o,
  output logic [col-1:0]         sat_o
);
  logic [depth-1:0][col*psum_bw-1:0] buf_q;
  logic [depth-1:0]                  loaded;
  logic [col*psum_bw-1:0]            sum_v, res_v;
  logic [col-1:0]                    lane_sat;
  logic                              accept, load;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  // A non-first beat to an unloaded entry is treated as a load.
  assign load     = in_first | ~loaded[in_addr];

  for (genvar c = 0; c < col; c++) begin : g_lane
    sfu_lane u_lane (
      .psum_in (psum_t'(psum_in[c*psum_bw +: psum_bw])),
      .buf_q   (psum_t'(buf_q[in_addr][c*psum_bw +: psum_bw])),
      .load    (load),
      .relu_en (relu_en),
      .sum     (sum_v[c*psum_bw +: psum_bw]),
      .res     (res_v[c*psum_bw +: psum_bw]),
      .sat     (lane_sat[c])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q     <= '0;
      loaded    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      psum_out  <= '0;
      err_o     <= 1'b0;
      sat_o     <= '0;
    end else begin
      err_o <= accept & ~bypass_i & ~in_first & ~loaded[in_addr];
      if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (bypass_i) begin
          out_valid <= 1'b1;
          out_addr  <= in_addr;
          psum_out  <= psum_in;
        end else begin
          buf_q[in_addr]  <= sum_v;
          loaded[in_addr] <= ~in_last;
          sat_o           <= sat_o | lane_sat;
          if (in_last) begin
            out_valid <= 1'b1;
            out_addr  <= in_addr;
            psum_out  <= res_v;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sfu_accum_buf.sv
// Directed self-checking bench for sfu_accum_buf (build with or without SFU_ACC_SAT_EN).
module tb_sfu_accum_buf;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int AW  = 4;

  logic                clk = 0;
  logic                reset_n;
  logic                in_valid, in_ready, in_first, in_last, bypass_i, relu_en;
  logic [AW-1:0]       in_addr, out_addr;
  logic [COL*BW-1:0]   psum_in, psum_out;
  logic                out_valid, out_ready, err_o;
  logic [COL-1:0]      sat_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sfu_accum_buf dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_first(in_first), .in_last(in_last), .bypass_i(bypass_i),
    .relu_en(relu_en), .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .psum_out(psum_out), .err_o(err_o), .sat_o(sat_o)
  );

  function automatic logic [COL*BW-1:0] rep(input logic [BW-1:0] v);
    return {COL{v}};
  endfunction

  task automatic chk(input string tag, input logic [COL*BW-1:0] obs, input logic [COL*BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one beat, wait (bounded) for in_ready, then complete the handshake.
  task automatic send(input logic [AW-1:0] a, input logic f, input logic l,
                      input logic byp, input logic r, input logic [BW-1:0] v);
    int n = 0;
    in_valid = 1; in_addr = a; in_first = f; in_last = l;
    bypass_i = byp; relu_en = r; psum_in = rep(v);
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n == 100) begin
      n_cmp++; n_err++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 0; in_first = 0; in_last = 0; bypass_i = 0; relu_en = 0;
  endtask

  initial begin
    reset_n = 0; in_valid = 0; in_addr = '0; in_first = 0; in_last = 0;
    bypass_i = 0; relu_en = 0; psum_in = '0; out_ready = 1;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", COL*BW'(out_valid), '0);
    chk("rst_psum_out", psum_out, '0);
    chk("rst_out_addr", COL*BW'(out_addr), '0);
    chk("rst_err", COL*BW'(err_o), '0);
    reset_n = 1;
    @(posedge clk); #1;

    // 1: load addr 3, reset mid-stream, then a first-less beat must flag err
    send(4'd3, 1, 0, 0, 0, 16'd9);
    in_valid = 1; in_addr = 4'd3; psum_in = rep(16'd1);
    #2 reset_n = 0;
    #1;
    chk("midrst_out_valid", COL*BW'(out_valid), '0);
    chk("midrst_sat", COL*BW'(sat_o), '0);
    in_valid = 0;
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    send(4'd3, 0, 0, 0, 0, 16'd4);
    chk("err_pulse", COL*BW'(err_o), COL*BW'(1));
    @(posedge clk); #1;
    chk("err_clear", COL*BW'(err_o), '0);
    send(4'd3, 1, 1, 0, 0, 16'd0);

    // 2: three passes to addr 5 -> -15
    send(4'd5, 1, 0, 0, 0, 16'd10);
    chk("p2_no_out_1", COL*BW'(out_valid), '0);
    send(4'd5, 0, 0, 0, 0, 16'd20);
    chk("p2_no_out_2", COL*BW'(out_valid), '0);
    chk("p2_no_err", COL*BW'(err_o), '0);
    send(4'd5, 0, 1, 0, 0, -16'sd45);
    chk("p2_valid", COL*BW'(out_valid), COL*BW'(1));
    chk("p2_sum", psum_out, rep(16'hFFF1));
    chk("p2_addr", COL*BW'(out_addr), COL*BW'(5));
    @(posedge clk); #1;
    chk("p2_drained", COL*BW'(out_valid), '0);

    // 3: ReLU on negative and positive results
    send(4'd5, 1, 0, 0, 1, 16'd10);
    send(4'd5, 0, 0, 0, 1, 16'd20);
    send(4'd5, 0, 1, 0, 1, -16'sd45);
    chk("p3_relu_neg", psum_out, '0);
    send(4'd5, 1, 0, 0, 1, 16'd10);
    send(4'd5, 0, 0, 0, 1, 16'd20);
    send(4'd5, 0, 1, 0, 1, 16'd50);
    chk("p3_relu_pos", psum_out, rep(16'd80));

    // 4: interleave addr 0/1 with a stall on the first result
    send(4'd0, 1, 0, 0, 0, 16'd1);
    send(4'd1, 1, 0, 0, 0, 16'd100);
    send(4'd0, 0, 0, 0, 0, 16'd2);
    send(4'd1, 0, 0, 0, 0, 16'd200);
    send(4'd0, 0, 0, 0, 0, 16'd3);
    send(4'd1, 0, 0, 0, 0, 16'd300);
    out_ready = 0;
    send(4'd0, 0, 1, 0, 0, 16'd4);
    chk("p4_r0_valid", COL*BW'(out_valid), COL*BW'(1));
    in_valid = 1; in_addr = 4'd1; in_first = 0; in_last = 1; psum_in = rep(16'd400);
    for (int i = 0; i < 3; i++) begin
      chk("p4_stall_ready", COL*BW'(in_ready), '0);
      chk("p4_hold_sum", psum_out, rep(16'd10));
      chk("p4_hold_addr", COL*BW'(out_addr), '0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    #1 chk("p4_ready_back", COL*BW'(in_ready), COL*BW'(1));
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    chk("p4_r1_sum", psum_out, rep(16'd1000));
    chk("p4_r1_addr", COL*BW'(out_addr), COL*BW'(1));

    // 5: bypass in the middle of an addr 2 accumulation
    send(4'd2, 1, 0, 0, 0, 16'd7);
    send(4'd2, 0, 0, 1, 1, 16'h8001);
    chk("p5_byp_data", psum_out, rep(16'h8001));
    chk("p5_byp_addr", COL*BW'(out_addr), COL*BW'(2));
    send(4'd2, 0, 1, 0, 0, 16'd8);
    chk("p5_final", psum_out, rep(16'd15));
    chk("p5_no_err", COL*BW'(err_o), '0);

    // 6: overflow behaviour
    chk("p6_sat_pre", COL*BW'(sat_o), '0);
    send(4'd7, 1, 0, 0, 0, 16'h7000);
    send(4'd7, 0, 1, 0, 0, 16'h2000);
`ifdef SFU_ACC_SAT_EN
    chk("p6_sum", psum_out, rep(16'h7FFF));
    chk("p6_sat", COL*BW'(sat_o), COL*BW'(8'hFF));
`else
    chk("p6_sum", psum_out, rep(16'h9000));
    chk("p6_sat", COL*BW'(sat_o), '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
